wca_write_word_reg: RTL and testbench

- Parametrised, multi-byte write-only control register on the 8-bit rbus.
- A WIDTH-bit value is written as NBYTES = WIDTH/8 consecutive byte writes to the single address my_addr, collected in a shadow register.
- The shadow commits to the output atomically after the last byte, so downstream logic never sees a half-updated word.
- A one-cycle update pulse and an optional read-back path make it the general successor to the single-byte write register.

---
 rtl/wca_write_word_reg.sv | 118 +++++++++++
 tb/tb_wca_write_word_reg.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wca_write_word_reg.sv
// Multi-byte rbus write register: bytes gather in a shadow, commit atomically.
// Optional read-back of the committed word: define WCA_WRITEREG_READBACK_EN.
module wca_write_word_reg #(
  parameter logic [7:0]       my_addr     = 8'h00,
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter bit               MSB_FIRST   = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [11:0]      rbusCtrl,
  inout  wire  [7:0]       rbusData,
  output logic [WIDTH-1:0] out,
  output logic             updated,
  output logic             busy
);

  localparam int NBYTES = WIDTH / 8;
  localparam int IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  if ((WIDTH % 8) != 0 || WIDTH < 8 || WIDTH > 64) begin : g_bad_width
    $error("WIDTH must be a multiple of 8 in 8..64");
  end

  logic             addr_valid;
  logic             wr_en;
  logic             strobe;
  logic             wr_stb;
  logic             abort;
  logic [IW-1:0]    idx;
  logic [IW-1:0]    lane;
  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] sh_nxt;
  logic [7:0]       din;

  assign addr_valid = (rbusCtrl[11:4] == my_addr);
  assign wr_en      = rbusCtrl[2];
  assign strobe     = rbusCtrl[1];
  assign wr_stb     = addr_valid & wr_en & strobe;
  // Leaving the address or dropping writeEnable ends a partial sequence;
  // a strobe gap with writeEnable still held only pauses it.
  assign abort      = (idx != '0) & ~(addr_valid & wr_en);
  assign din        = rbusData;
  assign busy       = (idx != '0);
  assign lane       = MSB_FIRST ? (LAST - idx) : idx;

  // Shadow with the current byte merged into its lane
  always_comb begin
    sh_nxt = shadow;
    for (int b = 0; b < NBYTES; b++) begin
      if (lane == IW'(b)) sh_nxt[b*8 +: 8] = din;
    end
  end

  // Byte collection, commit on the final byte, abort on bus departure
  always_ff @(posedge clock) begin
    if (reset) begin
      idx     <= '0;
      shadow  <= RESET_VALUE;
      out     <= RESET_VALUE;
      updated <= 1'b0;
    end else begin
      updated <= 1'b0;
      if (wr_stb) begin
        shadow <= sh_nxt;
        if (idx == LAST) begin
          out     <= sh_nxt;
          idx     <= '0;
          updated <= 1'b1;
        end else begin
          idx <= idx + IW'(1);
        end
      end else if (abort) begin
        idx <= '0;
      end
    end
  end

`ifdef WCA_WRITEREG_READBACK_EN
  logic          rd_en;
  logic [IW-1:0] ridx;
  logic [IW-1:0] rlane;
  logic [7:0]    rbyte;
  logic          unused_clkbus;

  assign unused_clkbus = rbusCtrl[0];
  assign rd_en         = addr_valid & rbusCtrl[3];
  assign rlane         = MSB_FIRST ? (LAST - ridx) : ridx;

  // Read index walks the committed word, cleared whenever reads stop
  always_ff @(posedge clock) begin
    if (reset) begin
      ridx <= '0;
    end else if (!rbusCtrl[3]) begin
      ridx <= '0;
    end else if (addr_valid && strobe) begin
      ridx <= (ridx == LAST) ? '0 : ridx + IW'(1);
    end
  end

  // Select the committed byte under the read lane
  always_comb begin
    rbyte = out[7:0];
    for (int b = 0; b < NBYTES; b++) begin
      if (rlane == IW'(b)) rbyte = out[b*8 +: 8];
    end
  end

  assign rbusData = rd_en ? rbyte : 8'bz;
`else
  logic unused_ctrl;

  assign unused_ctrl = ^{rbusCtrl[3], rbusCtrl[0]};
  assign rbusData    = 8'bz;
`endif

endmodule

// File: tb/tb_wca_write_word_reg.sv
// Randomised and directed bench for wca_write_word_reg.
// Three instances share one rbus at different addresses and widths.
module tb_wca_write_word_reg;

  logic        clock = 1'b0;
  logic        reset;
  logic [11:0] rbusCtrl;
  wire  [7:0]  rbusData;
  logic [7:0]  tdat;
  logic        toe;

  logic [31:0] o32;
  logic [7:0]  o8;
  logic [15:0] o16;
  logic        u32, u8, u16, b32, b8, b16;

  logic [63:0] dout [3];
  logic [2:0]  du, db;

  int ncmp = 0;
  int nerr = 0;

  localparam logic [7:0]  AD [3] = '{8'h20, 8'h30, 8'h40};
  localparam int          NB [3] = '{4, 1, 2};
  localparam bit          MF [3] = '{1'b0, 1'b0, 1'b1};
  localparam logic [63:0] RV [3] = '{64'hDEADBEEF, 64'hA5, 64'h1234};

  logic [7:0]  q  [3][$];
  logic [63:0] eo [3];
  bit          eu [3];

  assign rbusData = toe ? tdat : 8'bz;
  assign dout[0]  = {32'h0, o32};
  assign dout[1]  = {56'h0, o8};
  assign dout[2]  = {48'h0, o16};
  assign du       = {u16, u8, u32};
  assign db       = {b16, b8, b32};

  always #5 clock = ~clock;

  wca_write_word_reg #(
    .my_addr(8'h20), .WIDTH(32),
    .RESET_VALUE(32'hDEADBEEF), .MSB_FIRST(1'b0)
  ) u_w32 (
    .clock(clock), .reset(reset), .rbusCtrl(rbusCtrl),
    .rbusData(rbusData), .out(o32), .updated(u32), .busy(b32)
  );

  wca_write_word_reg #(
    .my_addr(8'h30), .WIDTH(8),
    .RESET_VALUE(8'hA5), .MSB_FIRST(1'b0)
  ) u_w8 (
    .clock(clock), .reset(reset), .rbusCtrl(rbusCtrl),
    .rbusData(rbusData), .out(o8), .updated(u8), .busy(b8)
  );

  wca_write_word_reg #(
    .my_addr(8'h40), .WIDTH(16),
    .RESET_VALUE(16'h1234), .MSB_FIRST(1'b1)
  ) u_w16 (
    .clock(clock), .reset(reset), .rbusCtrl(rbusCtrl),
    .rbusData(rbusData), .out(o16), .updated(u16), .busy(b16)
  );

  // One bus cycle: drive, advance the reference, clock, settle.
  task automatic cyc(input bit rst, input logic [7:0] a, input bit re,
                     input bit we, input bit ds, input logic [7:0] d);
    logic [63:0] v;
    int          pos;
    reset    = rst;
    rbusCtrl = {a, re, we, ds, 1'b0};
    tdat     = d;
    toe      = !re;
    for (int k = 0; k < 3; k++) begin
      eu[k] = 1'b0;
      if (rst) begin
        q[k].delete();
        eo[k] = RV[k];
      end else if (a == AD[k] && we && ds) begin
        q[k].push_back(d);
        if (q[k].size() == NB[k]) begin
          v = 64'h0;
          for (int i = 0; i < NB[k]; i++) begin
            pos = MF[k] ? NB[k] - 1 - i : i;
            v[pos*8 +: 8] = q[k][i];
          end
          eo[k] = v;
          eu[k] = 1'b1;
          q[k].delete();
        end
      end else if (q[k].size() != 0 && !(a == AD[k] && we)) begin
        q[k].delete();
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    cyc(1'b0, a, 1'b0, 1'b1, 1'b1, d);
  endtask

  task automatic idle();
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_reset();
    cyc(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    cyc(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int k = 0; k < 3; k++) begin
      ncmp++;
      if (dout[k] !== RV[k]) begin
        nerr++;
        $display("FAIL reset_out[%0d] got %h want %h", k, dout[k], RV[k]);
      end
      ncmp++;
      if (du[k] !== 1'b0 || db[k] !== 1'b0) begin
        nerr++;
        $display("FAIL reset_flags[%0d] got upd=%b busy=%b want 0 0",
                 k, du[k], db[k]);
      end
    end
    idle();
    wr(8'h20, 8'h9A);
    wr(8'h20, 8'h9B);
    ncmp++;
    if (b32 !== 1'b1) begin
      nerr++;
      $display("FAIL midseq_busy got %b want 1", b32);
    end
    cyc(1'b1, 8'h20, 1'b0, 1'b1, 1'b1, 8'h9C);
    ncmp++;
    if (b32 !== 1'b0 || o32 !== 32'hDEADBEEF || u32 !== 1'b0) begin
      nerr++;
      $display("FAIL midseq_reset got busy=%b out=%h upd=%b want 0 deadbeef 0",
               b32, o32, u32);
    end
    wr(8'h20, 8'h01);
    ncmp++;
    if (b32 !== 1'b1 || u32 !== 1'b0) begin
      nerr++;
      $display("FAIL restart_after_reset got busy=%b upd=%b want 1 0",
               b32, u32);
    end
    idle();
  endtask

  task automatic test_lsb_word();
    logic [7:0] bytes [4];
    int         pulses;
    bytes  = '{8'h11, 8'h22, 8'h33, 8'h44};
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      wr(8'h20, bytes[i]);
      pulses += int'(u32);
      ncmp++;
      if (b32 !== (i < 3)) begin
        nerr++;
        $display("FAIL lsb_busy[%0d] got %b want %b", i, b32, i < 3);
      end
      if (i < 3) begin
        ncmp++;
        if (o32 !== 32'hDEADBEEF) begin
          nerr++;
          $display("FAIL lsb_no_tear[%0d] got %h want deadbeef", i, o32);
        end
      end
    end
    ncmp++;
    if (o32 !== 32'h44332211) begin
      nerr++;
      $display("FAIL lsb_out got %h want 44332211", o32);
    end
    idle();
    pulses += int'(u32);
    idle();
    pulses += int'(u32);
    ncmp++;
    if (pulses != 1) begin
      nerr++;
      $display("FAIL lsb_pulses got %0d want 1", pulses);
    end
  endtask

  task automatic test_abort();
    wr(8'h20, 8'hAA);
    wr(8'h20, 8'hBB);
    cyc(1'b0, 8'h20, 1'b0, 1'b0, 1'b1, 8'hCC);
    ncmp++;
    if (b32 !== 1'b0 || u32 !== 1'b0 || o32 !== 32'h44332211) begin
      nerr++;
      $display("FAIL abort got busy=%b upd=%b out=%h want 0 0 44332211",
               b32, u32, o32);
    end
    for (int i = 1; i <= 4; i++) wr(8'h20, 8'(i));
    ncmp++;
    if (o32 !== 32'h04030201 || u32 !== 1'b1) begin
      nerr++;
      $display("FAIL abort_restart got out=%h upd=%b want 04030201 1",
               o32, u32);
    end
    idle();
  endtask

  task automatic test_addr_gap();
    for (int i = 0; i < 4; i++) wr(8'h21, 8'hE0 + 8'(i));
    ncmp++;
    if (o32 !== 32'h04030201 || u32 !== 1'b0 || b32 !== 1'b0) begin
      nerr++;
      $display("FAIL wrong_addr got out=%h upd=%b busy=%b want 04030201 0 0",
               o32, u32, b32);
    end
    wr(8'h20, 8'h10);
    cyc(1'b0, 8'h20, 1'b0, 1'b1, 1'b0, 8'hFF);
    ncmp++;
    if (b32 !== 1'b1) begin
      nerr++;
      $display("FAIL gap_hold got busy=%b want 1", b32);
    end
    wr(8'h20, 8'h20);
    cyc(1'b0, 8'h20, 1'b0, 1'b1, 1'b0, 8'hFE);
    cyc(1'b0, 8'h20, 1'b0, 1'b1, 1'b0, 8'hFD);
    wr(8'h20, 8'h30);
    ncmp++;
    if (u32 !== 1'b0 || o32 !== 32'h04030201) begin
      nerr++;
      $display("FAIL gap_no_advance got upd=%b out=%h want 0 04030201",
               u32, o32);
    end
    wr(8'h20, 8'h40);
    ncmp++;
    if (o32 !== 32'h40302010 || u32 !== 1'b1) begin
      nerr++;
      $display("FAIL gap_commit got out=%h upd=%b want 40302010 1", o32, u32);
    end
    idle();
  endtask

  task automatic test_byte();
    wr(8'h30, 8'h5A);
    ncmp++;
    if (o8 !== 8'h5A || u8 !== 1'b1 || b8 !== 1'b0) begin
      nerr++;
      $display("FAIL byte_commit got out=%h upd=%b busy=%b want 5a 1 0",
               o8, u8, b8);
    end
    idle();
    ncmp++;
    if (u8 !== 1'b0) begin
      nerr++;
      $display("FAIL byte_pulse_len got %b want 0", u8);
    end
    cyc(1'b1, 8'h30, 1'b0, 1'b1, 1'b1, 8'h77);
    ncmp++;
    if (o8 !== 8'hA5 || u8 !== 1'b0) begin
      nerr++;
      $display("FAIL byte_reset_prio got out=%h upd=%b want a5 0", o8, u8);
    end
    idle();
  endtask

  task automatic test_msb();
    wr(8'h40, 8'hAB);
    ncmp++;
    if (b16 !== 1'b1 || o16 !== 16'h1234) begin
      nerr++;
      $display("FAIL msb_partial got busy=%b out=%h want 1 1234", b16, o16);
    end
    wr(8'h40, 8'hCD);
    ncmp++;
    if (o16 !== 16'hABCD || u16 !== 1'b1) begin
      nerr++;
      $display("FAIL msb_out got out=%h upd=%b want abcd 1", o16, u16);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      wr(8'h20, 8'hC0 + 8'(i));
      if (i == 3 || i == 7) begin
        ncmp++;
        if (o32 !== (i == 3 ? 32'hC3C2C1C0 : 32'hC7C6C5C4) || u32 !== 1'b1) begin
          nerr++;
          $display("FAIL b2b[%0d] got out=%h upd=%b", i, o32, u32);
        end
      end
    end
    idle();
  endtask

  task automatic test_random();
    logic [7:0] al [4];
    al = '{8'h20, 8'h30, 8'h40, 8'h21};
    for (int n = 0; n < 400; n++) begin
      cyc(($urandom % 60) == 0, al[$urandom % 4], 1'b0,
          ($urandom % 5) != 0, ($urandom % 3) != 0, 8'($urandom));
      for (int k = 0; k < 3; k++) begin
        ncmp++;
        if (dout[k] !== eo[k] || du[k] !== eu[k] ||
            db[k] !== (q[k].size() != 0)) begin
          nerr++;
          $display("FAIL rand[%0d] dut%0d got out=%h upd=%b busy=%b want %h %b %b",
                   n, k, dout[k], du[k], db[k], eo[k], eu[k], q[k].size() != 0);
        end
      end
    end
  endtask

`ifdef WCA_WRITEREG_READBACK_EN
  task automatic test_readback();
    logic [7:0] exp [5];
    exp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
    idle();
    wr(8'h20, 8'h11);
    wr(8'h20, 8'h22);
    wr(8'h20, 8'h33);
    wr(8'h20, 8'h44);
    for (int i = 0; i < 5; i++) begin
      rbusCtrl = {8'h20, 1'b1, 1'b0, 1'b1, 1'b0};
      toe      = 1'b0;
      #1;
      ncmp++;
      if (rbusData !== exp[i]) begin
        nerr++;
        $display("FAIL readback[%0d] got %h want %h", i, rbusData, exp[i]);
      end
      cyc(1'b0, 8'h20, 1'b1, 1'b0, 1'b1, 8'h00);
    end
    rbusCtrl = {8'h20, 1'b0, 1'b0, 1'b0, 1'b0};
    tdat     = 8'hC3;
    toe      = 1'b1;
    #1;
    ncmp++;
    if (rbusData !== 8'hC3) begin
      nerr++;
      $display("FAIL readback_release got %h want c3", rbusData);
    end
    idle();
  endtask
`endif

  initial begin
    reset    = 1'b1;
    rbusCtrl = '0;
    tdat     = '0;
    toe      = 1'b1;
    test_reset();
    test_lsb_word();
    test_abort();
    test_addr_gap();
    test_byte();
    test_msb();
    test_back_to_back();
`ifdef WCA_WRITEREG_READBACK_EN
    test_readback();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
